song_grid_draw: RTL and testbench

SONG_GRID_DRAW -- requirements
Module: song_grid_draw

---
 rtl/song_grid_draw.sv | 131 +++++++++++++
 tb/tb_song_grid_draw.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/song_grid_draw.sv
// Note grid for a four-lane rhythm game: shifts one row per song step and
// repaints the 8x4 grid as 4x4-pixel cells, one pixel per clock.
module song_grid_draw #(
    parameter logic [7:0] X0 = 8'd40,
    parameter logic [6:0] Y0 = 7'd20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startGame,
    input  logic       shiftSong,
    input  logic       beatIncremented,
    input  logic       songDone,
    input  logic [3:0] newNotes,
    output logic       readyForSong,
    output logic [3:0] hitRow,
    output logic       hitValid,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [1:0] drawState
);

    // Handshake: shiftSong and beatIncremented are single-cycle strobes with no
    // back-pressure; readyForSong is a level that is high only while idle and armed.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2
    } drawState_t;

    drawState_t state, stateNext;

    logic [7:0][3:0] grid;
    logic [8:0]      cnt;
    logic            armed;

    logic [1:0] px, py, lane;
    logic [2:0] row;
    logic [7:0] pixX;
    logic [6:0] pixY;
    logic [2:0] cellColour;

    assign px   = cnt[1:0];
    assign py   = cnt[3:2];
    assign lane = cnt[5:4];
    assign row  = cnt[8:6];

    assign pixX = X0 + {3'b000, lane, 3'b000} + {6'b000000, px};
    assign pixY = Y0 + {1'b0, row, 3'b000} + {5'b00000, py};

    assign readyForSong = (state == IDLE) && armed;
    assign drawState    = state;

    always_comb begin
        cellColour = 3'b000;
        if (grid[row][lane]) begin
            case (lane)
                2'd0:    cellColour = 3'b100;
                2'd1:    cellColour = 3'b010;
                2'd2:    cellColour = 3'b001;
                default: cellColour = 3'b110;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (beatIncremented) stateNext = DRAW;
            DRAW:    if (cnt == 9'd511) stateNext = FLUSH;
            FLUSH:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 9'd0;
        end else begin
            state <= stateNext;
            // Held at zero outside DRAW so every draw starts from the top-left cell.
            if (state == DRAW) cnt <= cnt + 9'd1;
            else               cnt <= 9'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grid     <= '0;
            hitRow   <= 4'b0000;
            hitValid <= 1'b0;
        end else begin
            hitValid <= shiftSong;
            if (shiftSong) begin
                grid   <= {grid[6:0], newNotes};
                hitRow <= grid[6];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (startGame) begin
            armed <= 1'b1;
        end else if (songDone && readyForSong) begin
            armed <= 1'b0;
        end
    end

    // Pixel outputs trail the counter by one cycle; the grid is read live.
    always_ff @(posedge clock) begin
        if (reset) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'b000;
            plot   <= 1'b0;
        end else begin
            plot <= (state == DRAW);
            if (state == DRAW) begin
                x      <= pixX;
                y      <= pixY;
                colour <= cellColour;
            end
        end
    end

endmodule

// File: tb/tb_song_grid_draw.sv
// Directed bench for song_grid_draw: reset, arming, row shifts, full grid
// draws, re-triggered beats, song end and reset in the middle of a draw.
module tb_song_grid_draw;

    localparam logic [7:0] X0 = 8'd40;
    localparam logic [6:0] Y0 = 7'd20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       startGame = 1'b0;
    logic       shiftSong = 1'b0;
    logic       beatIncremented = 1'b0;
    logic       songDone = 1'b0;
    logic [3:0] newNotes = 4'b0000;
    logic       readyForSong;
    logic [3:0] hitRow;
    logic       hitValid;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [1:0] drawState;

    int nAsserts = 0;
    int nFails   = 0;
    int plots;

    logic [3:0] mGrid [8];

    song_grid_draw #(.X0(X0), .Y0(Y0)) dut (
        .clock(clock), .reset(reset), .startGame(startGame), .shiftSong(shiftSong),
        .beatIncremented(beatIncremented), .songDone(songDone), .newNotes(newNotes),
        .readyForSong(readyForSong), .hitRow(hitRow), .hitValid(hitValid),
        .x(x), .y(y), .colour(colour), .plot(plot), .drawState(drawState)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int r = 0; r < 8; r++) mGrid[r] = 4'b0000;
    endtask

    function automatic logic [2:0] laneColour(input int lane);
        case (lane)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    task automatic doShift(input logic [3:0] notes);
        newNotes  = notes;
        shiftSong = 1'b1;
        tick();
        shiftSong = 1'b0;
        newNotes  = 4'b0000;
        for (int r = 7; r > 0; r--) mGrid[r] = mGrid[r-1];
        mGrid[0] = notes;
        check("hitValid_pulse", {31'd0, hitValid}, 32'd1);
        check("hitRow", {28'd0, hitRow}, {28'd0, mGrid[7]});
        tick();
        check("hitValid_low", {31'd0, hitValid}, 32'd0);
    endtask

    task automatic beatPulse();
        beatIncremented = 1'b1;
        tick();
        beatIncremented = 1'b0;
        check("state_draw", {30'd0, drawState}, 32'd1);
        check("ready_in_draw", {31'd0, readyForSong}, 32'd0);
    endtask

    // k is the index of the plotted pixel, which equals the counter value it came from.
    task automatic checkPixel(input int k);
        int px, py, lane, row;
        logic [7:0] expX;
        logic [6:0] expY;
        logic [2:0] expC;
        px   = k & 3;
        py   = (k >> 2) & 3;
        lane = (k >> 4) & 3;
        row  = (k >> 6) & 7;
        expX = 8'(int'(X0) + 8 * lane + px);
        expY = 7'(int'(Y0) + 8 * row + py);
        expC = mGrid[row][lane] ? laneColour(lane) : 3'b000;
        check($sformatf("x[%0d]", k), {24'd0, x}, {24'd0, expX});
        check($sformatf("y[%0d]", k), {25'd0, y}, {25'd0, expY});
        check($sformatf("colour[%0d]", k), {29'd0, colour}, {29'd0, expC});
    endtask

    // Count plot cycles until the strobe drops; optionally re-pulse the beat or stop early.
    task automatic drawAndCount(input int reBeatAt, input int stopAt, output int n);
        n = 0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (plot) begin
                checkPixel(n);
                n++;
            end else if (n > 0) begin
                break;
            end
            beatIncremented = (n == reBeatAt);
            if (stopAt > 0 && n == stopAt) break;
        end
        beatIncremented = 1'b0;
    endtask

    initial begin
        clearModel();
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", {31'd0, readyForSong}, 32'd0);
        check("rst_hitRow", {28'd0, hitRow}, 32'd0);
        check("rst_hitValid", {31'd0, hitValid}, 32'd0);
        check("rst_plot", {31'd0, plot}, 32'd0);
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_y", {25'd0, y}, 32'd0);
        check("rst_colour", {29'd0, colour}, 32'd0);
        check("rst_state", {30'd0, drawState}, 32'd0);

        tick();
        check("ready_unarmed", {31'd0, readyForSong}, 32'd0);
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        check("ready_armed", {31'd0, readyForSong}, 32'd1);

        // A single note walks down to the hit line in eight shifts.
        doShift(4'b0001);
        for (int i = 0; i < 7; i++) doShift(4'b0000);
        check("hitRow_after8", {28'd0, hitRow}, 32'd1);

        // Lane 3 note in row 0 only; full draw.
        doShift(4'b1000);
        beatPulse();
        drawAndCount(-1, 0, plots);
        check("plot_count", plots, 32'd512);
        check("ready_after_draw", {31'd0, readyForSong}, 32'd1);
        check("state_idle_after", {30'd0, drawState}, 32'd0);

        // Beat re-pulsed 100 plots into the draw must not extend it.
        beatPulse();
        drawAndCount(100, 0, plots);
        check("plot_count_rebeat", plots, 32'd512);
        check("ready_after_rebeat", {31'd0, readyForSong}, 32'd1);

        // startGame wins over songDone; songDone alone disarms.
        songDone  = 1'b1;
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        check("ready_start_priority", {31'd0, readyForSong}, 32'd1);
        tick();
        songDone = 1'b0;
        check("ready_song_done", {31'd0, readyForSong}, 32'd0);
        tick();
        tick();
        check("ready_stays_low", {31'd0, readyForSong}, 32'd0);

        // Populate several lanes, then reset 200 plots into a draw.
        doShift(4'b1111);
        beatPulse();
        drawAndCount(-1, 200, plots);
        check("plots_before_reset", plots, 32'd200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clearModel();
        check("reset_plot", {31'd0, plot}, 32'd0);
        check("reset_state", {30'd0, drawState}, 32'd0);
        check("reset_hitRow", {28'd0, hitRow}, 32'd0);
        check("reset_ready", {31'd0, readyForSong}, 32'd0);
        check("reset_colour", {29'd0, colour}, 32'd0);

        // Redraw shows an empty grid.
        beatPulse();
        drawAndCount(-1, 0, plots);
        check("plot_count_post_reset", plots, 32'd512);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
